bus_xfer_ctrl: RTL and testbench

- Sits directly downstream of the two-master fixed-priority arbiter. It consumes gnt_0 (CPU) and gnt_1 (DMA).
- Locks bus ownership to the granted master for the full duration of one transaction.
- Drives the winning master's latched address, write data and direction onto the shared bus (towards the address decoder and slaves).
- Routes read data and completion back only to the owning master; a timeout counter terminates hung slaves with an error.

---
 rtl/soc_bus_pkg.sv | 14 +
 rtl/xfer_timeout_cnt.sv | 24 ++
 rtl/bus_xfer_ctrl.sv | 94 +++++++++
 tb/tb_bus_xfer_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared bus definitions: transfer FSM encoding, master IDs and default widths.
package soc_bus_pkg;
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } xfer_state_e;
endpackage

// File: rtl/xfer_timeout_cnt.sv
// Saturating cycle counter with a terminal-count flag; LIMIT = 0 disables the flag.
module xfer_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + 1'b1;
  end

  // Flag is raised on the last allowed wait cycle so the owner can terminate on that edge.
  assign expired = (LIMIT != 0) && (cnt == LAST);
endmodule

// File: rtl/bus_xfer_ctrl.sv
// Locks the shared bus to the granted master for one transaction and routes completion back.
module bus_xfer_ctrl
  import soc_bus_pkg::*;
#(
  parameter int ADDR_W         = BUS_ADDR_W,
  parameter int DATA_W         = BUS_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_wr,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_err,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wr,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic              busy,
  output logic              owner
);
  xfer_state_e state;
  logic        expired;

  xfer_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == IDLE),
    .en      (state == BUSY && !bus_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m_rdata   <= '0;
      m_err     <= 1'b0;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wr    <= 1'b0;
      busy      <= 1'b0;
      owner     <= MST_CPU;
    end else begin
      case (state)
        IDLE: begin
          // Simultaneous grants are an arbiter fault; CPU takes the bus.
          if (gnt_0 || gnt_1) begin
            owner     <= gnt_0 ? MST_CPU : MST_DMA;
            bus_addr  <= gnt_0 ? m0_addr  : m1_addr;
            bus_wdata <= gnt_0 ? m0_wdata : m1_wdata;
            bus_wr    <= gnt_0 ? m0_wr    : m1_wr;
            bus_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus_ready || expired) begin
            m_rdata   <= bus_ready ? bus_rdata : '0;
            m_err     <= !bus_ready;
            bus_valid <= 1'b0;
            m0_ack    <= (owner == MST_CPU);
            m1_ack    <= (owner == MST_DMA);
            state     <= DONE;
          end
        end
        DONE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          m_err  <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl with an 8-cycle timeout.
module tb_bus_xfer_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          gnt_0, gnt_1;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_wr, m1_wr;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m_rdata;
  logic          m_err;
  logic          bus_valid;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_wr;
  logic [DW-1:0] bus_rdata;
  logic          bus_ready;
  logic          busy;
  logic          owner;

  int tests = 0;
  int fails = 0;

  bus_xfer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr(m0_wr),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr(m1_wr),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m_rdata(m_rdata), .m_err(m_err),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wr(bus_wr), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; gnt_0 = 0; gnt_1 = 0;
    m0_addr = '0; m0_wdata = '0; m0_wr = 0;
    m1_addr = '0; m1_wdata = '0; m1_wr = 0;
    bus_rdata = '0; bus_ready = 0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_acks", {m0_ack, m1_ack, m_err, owner}, 0);
    rst_n = 1'b1;
    step();

    // CPU read, ready on the third BUSY cycle
    gnt_0 = 1; m0_addr = 32'h0000_1000; m0_wr = 0;
    step();
    gnt_0 = 0;
    chk("rd_valid1", bus_valid, 1);
    chk("rd_addr", bus_addr, 32'h1000);
    chk("rd_owner", {busy, owner}, 2'b10);
    step();
    chk("rd_valid2", bus_valid, 1);
    step();
    chk("rd_valid3", bus_valid, 1);
    bus_ready = 1; bus_rdata = 32'hCAFE_0001;
    step();
    bus_ready = 0;
    chk("rd_ack", {m0_ack, m1_ack, m_err, bus_valid}, 4'b1000);
    chk("rd_rdata", m_rdata, 32'hCAFE_0001);
    step();
    chk("rd_after", {m0_ack, m1_ack, busy}, 0);
    chk("rd_hold", m_rdata, 32'hCAFE_0001);

    // DMA write with a competing CPU grant mid-transaction
    gnt_1 = 1; m1_addr = 32'h2000_0040; m1_wdata = 32'h55AA_55AA; m1_wr = 1;
    step();
    chk("dw_addr", bus_addr, 32'h2000_0040);
    chk("dw_wdata", bus_wdata, 32'h55AA_55AA);
    chk("dw_owner", {owner, bus_wr}, 2'b11);
    gnt_1 = 0; gnt_0 = 1; m0_addr = 32'h3000; m0_wr = 0;
    step();
    chk("dw_lock_addr", bus_addr, 32'h2000_0040);
    chk("dw_lock_wr", {owner, bus_wr, bus_valid}, 3'b111);
    bus_ready = 1; bus_rdata = 32'h0;
    step();
    bus_ready = 0;
    chk("dw_ack", {m0_ack, m1_ack}, 2'b01);
    step();
    chk("dw_idle", {busy, m0_ack, m1_ack, bus_valid}, 0);
    step();
    chk("dw_cpu_start", {busy, owner, bus_valid}, 3'b101);
    chk("dw_cpu_addr", bus_addr, 32'h3000);
    gnt_0 = 0; bus_ready = 1; bus_rdata = 32'h1111;
    step();
    bus_ready = 0;
    chk("dw_cpu_ack", {m0_ack, m1_ack}, 2'b10);
    step();

    // Simultaneous grants: CPU wins
    gnt_0 = 1; gnt_1 = 1; m0_addr = 32'hA0; m1_addr = 32'hB0;
    step();
    gnt_0 = 0; gnt_1 = 0;
    chk("sim_owner", owner, 0);
    chk("sim_addr", bus_addr, 32'hA0);
    bus_ready = 1;
    step();
    bus_ready = 0;
    chk("sim_ack", {m0_ack, m1_ack}, 2'b10);
    step();

    // Timeout: eight BUSY cycles, then error ack with zeroed data
    gnt_0 = 1; m0_addr = 32'h44; bus_rdata = 32'hDEAD_BEEF;
    step();
    gnt_0 = 0;
    chk("to_valid_c1", bus_valid, 1);
    for (int i = 0; i < 6; i++) step();
    chk("to_valid_c7", {bus_valid, m0_ack}, 2'b10);
    step();
    chk("to_valid_c8", {bus_valid, m0_ack}, 2'b10);
    step();
    chk("to_ack", {bus_valid, m0_ack, m1_ack, m_err}, 4'b0101);
    chk("to_rdata", m_rdata, 0);
    step();
    chk("to_clear", {m0_ack, m_err, busy}, 0);

    // Ready on the 8th BUSY cycle beats the timeout
    gnt_0 = 1; m0_addr = 32'h48;
    step();
    gnt_0 = 0;
    for (int i = 0; i < 7; i++) step();
    bus_ready = 1; bus_rdata = 32'h77;
    step();
    bus_ready = 0;
    chk("to_ready_ack", {m0_ack, m_err}, 2'b10);
    chk("to_ready_rdata", m_rdata, 32'h77);
    step();

    // Asynchronous reset while BUSY
    gnt_0 = 1; m0_addr = 32'h500;
    step();
    gnt_0 = 0;
    chk("ar_busy", {busy, bus_valid}, 2'b11);
    rst_n = 0;
    #1;
    chk("ar_async", {busy, bus_valid, m0_ack, m1_ack, m_err, owner}, 0);
    chk("ar_addr", bus_addr, 0);
    chk("ar_rdata", m_rdata, 0);
    bus_ready = 1;
    step();
    chk("ar_noack", {m0_ack, m1_ack, busy}, 0);
    rst_n = 1; bus_ready = 0;
    step();
    gnt_0 = 1; m0_addr = 32'h520;
    step();
    gnt_0 = 0;
    chk("ar_fresh_addr", bus_addr, 32'h520);
    bus_ready = 1; bus_rdata = 32'h1234_5678;
    step();
    bus_ready = 0;
    chk("ar_fresh_ack", {m0_ack, m_err}, 2'b10);
    chk("ar_fresh_rdata", m_rdata, 32'h1234_5678);
    step();

    // Back-to-back with gnt_0 and ready held: acks on edges 2 and 5
    gnt_0 = 1; m0_addr = 32'h600; bus_ready = 1; bus_rdata = 32'hAB;
    step();
    chk("bb_addr1", bus_addr, 32'h600);
    m0_addr = 32'h700;
    step();
    chk("bb_ack1", m0_ack, 1);
    step();
    chk("bb_gap", {m0_ack, busy}, 0);
    step();
    chk("bb_addr2", {busy, bus_addr}, {1'b1, 32'h700});
    gnt_0 = 0;
    step();
    chk("bb_ack2", {m0_ack, m1_ack}, 2'b10);
    bus_ready = 0;
    step();
    chk("bb_end", {m0_ack, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
